// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch pipeline stage. It holds the program counter, issues
// single-word reads to instruction memory and registers each returned word
// into the IF/ID pipeline register that feeds decode. A small BOOT/RUN/HALT
// state machine sequences start-up and stops fetching after a HLT opcode
// (imem_rdata[15:13] == 3'b111).
//
// Optional feature (compile-time macro FETCH_REDIRECT_EN):
//   defined   - redirect_valid loads redirect_pc into the PC, squashes IF/ID
//               to a bubble and forces RUN from any state, overriding stall.
//   undefined - redirect_valid / redirect_pc are present but ignored, and
//               HALT is left only through reset.
//
// Parameters:
//   ADDR_WIDTH - PC / instruction-memory word-address width
//   RESET_PC   - PC value loaded by reset
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   downstream hazard hold request
//   redirect_valid in   branch/jump taken strobe
//   redirect_pc    in   branch/jump target address
//   imem_req       out  instruction-memory read request
//   imem_addr      out  read address (always the current PC)
//   imem_ready     in   imem_rdata is valid this cycle for the request
//   imem_rdata     in   instruction word from memory
//   instruction    out  IF/ID instruction register (16'h0000 for a bubble)
//   pc_out         out  IF/ID address of instruction
//   if_valid       out  1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_stage #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [15:0]           imem_rdata,
    output logic [15:0]           instruction,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  if_valid
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   pc_r, pc_s;
    logic [15:0]             instr_r, instr_s;
    logic [ADDR_WIDTH-1:0]   pc_out_r, pc_out_s;
    logic                    valid_r, valid_s;
    logic                    redirect_s;
    logic [ADDR_WIDTH-1:0]   redirect_target_s;
    logic [ADDR_WIDTH-1:0]   pc_inc_s;

    // HLT opcode lives in the top three bits of the instruction word.
    function automatic logic is_halt_op(input logic [15:0] word);
        return (word[15:13] == 3'b111);
    endfunction

`ifdef FETCH_REDIRECT_EN
    assign redirect_s        = redirect_valid;
    assign redirect_target_s = redirect_pc;
`else
    // Redirect disabled: ports stay on the boundary but never affect state.
    logic unused_redirect_s;
    assign redirect_s        = 1'b0;
    assign redirect_target_s = pc_r;
    assign unused_redirect_s = ^{redirect_valid, redirect_pc};
`endif

    // Natural truncation to ADDR_WIDTH gives the all-ones -> 0 wrap.
    assign pc_inc_s = pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // A request is only raised when this cycle can actually consume the word;
    // reset drops it so an outstanding wait is abandoned immediately.
    assign imem_req    = (state_r == ST_RUN) && !stall && !redirect_s && !rst;
    assign imem_addr   = pc_r;
    assign instruction = instr_r;
    assign pc_out      = pc_out_r;
    assign if_valid    = valid_r;

    // Next-state and IF/ID update: priority redirect > stall > fetch.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        instr_s  = instr_r;
        pc_out_s = pc_out_r;
        valid_s  = valid_r;
        if (redirect_s) begin
            pc_s    = redirect_target_s;
            instr_s = 16'h0000;
            valid_s = 1'b0;
            state_s = ST_RUN;
        end else if (stall) begin
            // Full hold: PC, IF/ID and state keep their values.
            state_s = state_r;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_s = ST_RUN;
                    instr_s = 16'h0000;
                    valid_s = 1'b0;
                end
                ST_RUN: begin
                    if (imem_ready) begin
                        instr_s  = imem_rdata;
                        pc_out_s = pc_r;
                        valid_s  = 1'b1;
                        pc_s     = pc_inc_s;
                        if (is_halt_op(imem_rdata)) begin
                            state_s = ST_HALT;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        // Wait for memory: insert a bubble and re-request.
                        instr_s = 16'h0000;
                        valid_s = 1'b0;
                    end
                end
                ST_HALT: begin
                    instr_s = 16'h0000;
                    valid_s = 1'b0;
                end
                default: begin
                    // Illegal encoding: recover through a BOOT cycle.
                    state_s = ST_BOOT;
                    instr_s = 16'h0000;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_PC;
            instr_r  <= 16'h0000;
            pc_out_r <= {ADDR_WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            instr_r  <= instr_s;
            pc_out_r <= pc_out_s;
            valid_r  <= valid_s;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL be the PC / instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 0, SHALL be the PC value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 stall  input  1  SHALL be the hazard hold request from downstream.
REQ-006 redirect_valid  input  1  SHALL be the branch/jump taken strobe.
REQ-007 redirect_pc  input  ADDR_WIDTH  SHALL be the branch/jump target address.
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  output  ADDR_WIDTH  SHALL be the read address, always equal to current PC.
REQ-010 imem_ready  input  1  SHALL indicate imem_rdata valid this cycle for the request.
REQ-011 imem_rdata  input  16  SHALL be the instruction word.
REQ-012 instruction  output  16  SHALL be the registered IF/ID instruction feeding decode.
REQ-013 pc_out  output  ADDR_WIDTH  SHALL be the registered address of instruction.
REQ-014 if_valid  output  1  SHALL flag instruction as real (1) or bubble (0).

Function
REQ-015 State machine SHALL have states BOOT, RUN, HALT; BOOT lasts exactly one cycle then goes to RUN.
REQ-016 imem_req SHALL be 1 only in RUN with stall=0 and no redirect this cycle; 0 otherwise.
REQ-017 Bubble SHALL mean instruction=16'h0000, if_valid=0, pc_out unchanged.
REQ-018 RUN, stall=0, imem_ready=1: next edge IF/ID <= {imem_rdata, PC, 1}; PC <= PC+1.
REQ-019 RUN, stall=0, imem_ready=0: next edge IF/ID <= bubble; PC holds; request repeats.
REQ-020 PC increment SHALL wrap modulo 2^ADDR_WIDTH (all-ones -> 0).
REQ-021 Fetched word with imem_rdata[15:13]=3'b111 (HLT) SHALL be latched normally, PC SHALL increment, state -> HALT.
REQ-022 HALT: imem_req=0, PC holds, IF/ID <= bubble every cycle.
REQ-023 stall=1 (no redirect): PC, IF/ID and state SHALL all hold; imem_ready ignored.
REQ-024 Priority SHALL be rst > redirect > stall > normal fetch.
REQ-025 Fetch latency: instruction at PC SHALL appear on instruction the edge after imem_ready=1 with stall=0.

Reset
REQ-026 rst=1 at an edge SHALL set PC=RESET_PC, state=BOOT, instruction=16'h0000, pc_out=0, if_valid=0, regardless of stall/redirect.
REQ-027 Reset mid-wait (imem_ready=0 outstanding) SHALL abandon the request; no response is consumed afterwards until RUN.

Configuration
REQ-028 Macro FETCH_REDIRECT_EN defined: redirect_valid=1 at an edge SHALL set PC<=redirect_pc, IF/ID<=bubble, state<=RUN (including from HALT and BOOT), overriding stall.
REQ-029 FETCH_REDIRECT_EN undefined: redirect ports SHALL remain present but be ignored; HALT SHALL exit only by reset.

Verification
REQ-030 Reset then imem_ready=1 constant, memory[i]=16'h1000+i -> cycle 1 BOOT no req; then instruction=16'h1000,16'h1001,... pc_out=0,1,... if_valid=1.
REQ-031 Stall=1 for 3 cycles while instruction=16'h1002 -> instruction, pc_out=2, imem_addr=3 hold; resumes with 16'h1003.
REQ-032 imem_ready=0 for 2 cycles at PC=5 -> two bubbles (if_valid=0), imem_addr stays 5; then word from address 5 appears.
REQ-033 memory[4]=16'hE000 -> instruction=16'hE000 valid, then permanent bubbles, imem_req=0, PC=5.
REQ-034 (FETCH_REDIRECT_EN) redirect_valid=1, redirect_pc=10'h3FF with stall=1 -> bubble, PC=3FF; next fetches 3FF then wraps to 0.
REQ-035 rst=1 with redirect_valid=1 and stall=1 -> reset values per REQ-026, BOOT next.
